// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: round-robin result collection onto the CDB with tag-checked regfile writeback
module cdb_writeback_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 4,
    parameter int XLEN    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC*TAG_W-1:0] src_tag,
    input  logic [NUM_SRC*5-1:0]     src_rd,
    input  logic [NUM_SRC*XLEN-1:0]  src_data,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [4:0]               cdb_rd,
    output logic [XLEN-1:0]          cdb_data,
    input  logic                     rat_tag_match,
    output logic                     RegWrite,
    output logic [4:0]               writeaddr,
    output logic [31:0]              writedata,
    output logic                     err_tag0
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0] slot_v, grant, hs, tag0;
    logic [TAG_W-1:0]   slot_tag [NUM_SRC];
    logic [4:0]         slot_rd [NUM_SRC];
    logic [XLEN-1:0]    slot_data [NUM_SRC];
    logic [PW-1:0]      rr_ptr, gnt_idx, scan_idx;
    logic               gnt_found;

    // Scan starts at rr_ptr and wraps, so the most recently served source is checked last
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = PW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!gnt_found && slot_v[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_tag0
        assign tag0[g] = src_tag[g*TAG_W +: TAG_W] == '0;
    end

    assign grant     = gnt_found ? NUM_SRC'(1) << gnt_idx : '0;
    assign src_ready = {NUM_SRC{!flush}} & (~slot_v | grant);
    assign hs        = src_valid & src_ready;
    assign RegWrite  = cdb_valid && rat_tag_match && cdb_rd != 5'd0;
    assign writeaddr = cdb_rd;
    assign writedata = 32'(cdb_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v    <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_rd    <= '0;
            cdb_data  <= '0;
            err_tag0  <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_tag[i]  <= '0;
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else if (flush) begin
            slot_v    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= gnt_found;
            if (gnt_found) begin
                cdb_tag  <= slot_tag[gnt_idx];
                cdb_rd   <= slot_rd[gnt_idx];
                cdb_data <= slot_data[gnt_idx];
                rr_ptr   <= gnt_idx == PW'(NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
            end
            // Tag-0 results complete the handshake but never occupy the slot
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs[i]) begin
                    slot_v[i]    <= !tag0[i];
                    slot_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
                    slot_rd[i]   <= src_rd[i*5 +: 5];
                    slot_data[i] <= src_data[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
            if (|(hs & tag0)) err_tag0 <= 1'b1;
        end
    end
endmodule
